// File: rtl/ramb16_s2_fifo_ctrl_pkg.sv
// Shared constants and types for the RAMB16 8192x2 FIFO controller.
// Holds the depth and pointer-width helpers, the RAM symbol width, the RAM tie-offs and the status-flag bundle.
package ramb16_s2_fifo_ctrl_pkg;

  localparam int SYM_W = 2;

  localparam logic RAM_WEB_TIE = 1'b0;
  localparam logic RAM_SSR_TIE = 1'b0;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One extra bit beyond the RAM address acts as the wrap bit for full/empty.
  function automatic int ptr_w_of(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ramb16_s2_fifo_ctrl_ptr_ctr.sv
// Binary FIFO pointer with a wrap bit.
// Exposes the current RAM address and the next full-width pointer value, which the top uses to register its flags.
module ramb16_s2_fifo_ctrl_ptr_ctr
  import ramb16_s2_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  output logic [ADDR_W-1:0]        addr,
  output logic [ptr_w_of(ADDR_W)-1:0] ptr_nxt
);

  localparam int PTR_W = ptr_w_of(ADDR_W);

  logic [PTR_W-1:0] ptr_q;

  always_comb ptr_nxt = ptr_q + PTR_W'(inc);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_nxt;
  end

  assign addr = ptr_q[ADDR_W-1:0];

endmodule

// File: rtl/ramb16_s2_fifo_ctrl.sv
// Single-clock FIFO controller driving a 16Kb dual-port block RAM (port A push, port B pop).
// Owns pointers, occupancy, flags and sticky error bits, and valid-qualifies the RAM's registered read data.
module ramb16_s2_fifo_ctrl
  import ramb16_s2_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 13,
  parameter int AFULL_THRESH  = 8184,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [SYM_W-1:0]      WR_DATA,
  input  logic                  RD_EN,
  output logic [SYM_W-1:0]      RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [ADDR_WIDTH-1:0] RAM_ADDRA,
  output logic [SYM_W-1:0]      RAM_DIA,
  output logic                  RAM_ENA,
  output logic                  RAM_WEA,
  output logic [ADDR_WIDTH-1:0] RAM_ADDRB,
  output logic                  RAM_ENB,
  output logic                  RAM_WEB,
  output logic                  RAM_SSRA,
  output logic                  RAM_SSRB,
  input  logic [SYM_W-1:0]      RAM_DOB
);

  localparam int PTR_W = ptr_w_of(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AF_T = PTR_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] AE_T = PTR_W'(AEMPTY_THRESH);

  logic             push_ok, pop_ok;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [PTR_W-1:0] count_d, count_q;
  fifo_flags_t      flags_d, flags_q;
  logic             rd_valid_d, rd_valid_q;
  logic             ovf_d, ovf_q;
  logic             unf_d, unf_q;

  ramb16_s2_fifo_ctrl_ptr_ctr #(.ADDR_W(ADDR_WIDTH)) u_wr_ptr (
    .clk     (CLK),
    .rst     (RST),
    .inc     (push_ok),
    .addr    (RAM_ADDRA),
    .ptr_nxt (wr_ptr_nxt)
  );

  ramb16_s2_fifo_ctrl_ptr_ctr #(.ADDR_W(ADDR_WIDTH)) u_rd_ptr (
    .clk     (CLK),
    .rst     (RST),
    .inc     (pop_ok),
    .addr    (RAM_ADDRB),
    .ptr_nxt (rd_ptr_nxt)
  );

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    push_ok = WR_EN & ~flags_q.full  & ~RST;
    pop_ok  = RD_EN & ~flags_q.empty & ~RST;

    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: ;
    endcase

    // Flags are registered from the post-edge pointers so they track COUNT cycle for cycle.
    flags_d.empty  = (wr_ptr_nxt == rd_ptr_nxt);
    flags_d.full   = (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
    flags_d.afull  = (count_d >= AF_T);
    flags_d.aempty = (count_d <= AE_T);

    rd_valid_d = pop_ok;
    ovf_d      = ovf_q | (WR_EN & flags_q.full);
    unf_d      = unf_q | (RD_EN & flags_q.empty);
  end

  // RAM contents are deliberately left alone on reset; only control state is cleared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q    <= '0;
      flags_q    <= FLAGS_RST;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      flags_q    <= flags_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign RD_VALID     = rd_valid_q;
  assign RD_DATA      = rd_valid_q ? RAM_DOB : '0;
  assign FULL         = flags_q.full;
  assign EMPTY        = flags_q.empty;
  assign ALMOST_FULL  = flags_q.afull;
  assign ALMOST_EMPTY = flags_q.aempty;
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

  assign RAM_DIA  = WR_DATA;
  assign RAM_ENA  = push_ok;
  assign RAM_WEA  = push_ok;
  assign RAM_ENB  = pop_ok;
  assign RAM_WEB  = RAM_WEB_TIE;
  assign RAM_SSRA = RAM_SSR_TIE;
  assign RAM_SSRB = RAM_SSR_TIE;

endmodule

// File: tb/tb_ramb16_s2_fifo_ctrl.sv
// Scoreboard bench for ramb16_s2_fifo_ctrl at ADDR_WIDTH=3 with a behavioural 8x2 RAM alongside.
// A queue-based occupancy model predicts port activity; popped symbols go to an expect queue drained by the monitor.
module tb_ramb16_s2_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          WR_EN = 1'b0;
  logic [1:0]    WR_DATA = 2'b00;
  logic          RD_EN = 1'b0;
  logic [1:0]    RD_DATA;
  logic          RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
  logic [AW:0]   COUNT;
  logic          OVERFLOW, UNDERFLOW;
  logic [AW-1:0] RAM_ADDRA, RAM_ADDRB;
  logic [1:0]    RAM_DIA, RAM_DOB;
  logic          RAM_ENA, RAM_WEA, RAM_ENB, RAM_WEB, RAM_SSRA, RAM_SSRB;

  ramb16_s2_fifo_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .FULL(FULL), .EMPTY(EMPTY),
    .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA),
    .RAM_ADDRB(RAM_ADDRB), .RAM_ENB(RAM_ENB), .RAM_WEB(RAM_WEB),
    .RAM_SSRA(RAM_SSRA), .RAM_SSRB(RAM_SSRB), .RAM_DOB(RAM_DOB)
  );

  always #5 CLK = ~CLK;

  // Behavioural block RAM: write on port A, registered read on port B.
  logic [1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DIA;
    if (RAM_ENB)            RAM_DOB <= mem[RAM_ADDRB];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents, push/pop totals since reset, sticky errors.
  logic [1:0] mq[$];
  logic [1:0] exp_q[$];
  int  m_pushes = 0, m_pops = 0;
  bit  m_ovf = 0, m_unf = 0, m_valid = 0;
  bit  mon_on = 0;

  always @(negedge CLK) begin
    if (mon_on) begin
      check("count",        COUNT,        mq.size());
      check("empty",        EMPTY,        mq.size() == 0);
      check("full",         FULL,         mq.size() == DEPTH);
      check("almost_full",  ALMOST_FULL,  mq.size() >= AF);
      check("almost_empty", ALMOST_EMPTY, mq.size() <= AE);
      check("overflow",     OVERFLOW,     m_ovf);
      check("underflow",    UNDERFLOW,    m_unf);
      check("rd_valid",     RD_VALID,     m_valid);
      if (RD_VALID) begin
        if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else                   check("rd_data", RD_DATA, exp_q.pop_front());
      end else begin
        check("rd_data_gated", RD_DATA, 0);
      end
    end
  end

  task automatic cycle(input bit rst, input bit we, input logic [1:0] wd, input bit re);
    bit ep, eo;
    @(negedge CLK);
    #2;
    RST = rst; WR_EN = we; WR_DATA = wd; RD_EN = re;
    #1;
    ep = !rst && we && (mq.size() < DEPTH);
    eo = !rst && re && (mq.size() > 0);
    check("ram_ena", RAM_ENA, ep);
    check("ram_wea", RAM_WEA, ep);
    check("ram_enb", RAM_ENB, eo);
    check("ram_ties", {RAM_WEB, RAM_SSRA, RAM_SSRB}, 0);
    if (ep) begin
      check("ram_addra", RAM_ADDRA, m_pushes % DEPTH);
      check("ram_dia",   RAM_DIA,   wd);
    end
    if (eo) check("ram_addrb", RAM_ADDRB, m_pops % DEPTH);
    if (rst) begin
      mq.delete(); exp_q.delete();
      m_pushes = 0; m_pops = 0; m_ovf = 0; m_unf = 0; m_valid = 0;
    end else begin
      if (we && mq.size() == DEPTH) m_ovf = 1;
      if (re && mq.size() == 0)     m_unf = 1;
      if (eo) begin exp_q.push_back(mq.pop_front()); m_pops++; end
      if (ep) begin mq.push_back(wd); m_pushes++; end
      m_valid = eo;
    end
  endtask

  task automatic push(input logic [1:0] d); cycle(0, 1, d, 0); endtask
  task automatic pop();                    cycle(0, 0, 2'b00, 1); endtask
  task automatic idle();                   cycle(0, 0, 2'b00, 0); endtask

  initial begin
    // Reset with requests pending: RAM enables must stay low while RST is high.
    cycle(1, 1, 2'b11, 1);
    mon_on = 1;
    cycle(1, 0, 2'b00, 0);

    // Three pushes then three pops.
    push(2'b01); push(2'b10); push(2'b11);
    pop(); pop(); pop();
    idle();

    // Fill to full, then push into a full FIFO.
    for (int i = 0; i < DEPTH; i++) push(2'(i));
    push(2'b10);
    idle();

    // Push+pop at full, then 20 cycles of push+pop across the wrap.
    cycle(0, 1, 2'b01, 1);
    for (int i = 0; i < 20; i++) cycle(0, 1, 2'($urandom_range(0, 3)), 1);
    for (int i = 0; i < DEPTH; i++) pop();
    idle();

    // Pop on empty, then push+pop on empty.
    pop();
    cycle(0, 1, 2'b11, 1);
    idle();

    // Reset one cycle after a pop with data in the FIFO.
    cycle(1, 0, 2'b00, 0);
    for (int i = 0; i < 5; i++) push(2'($urandom_range(0, 3)));
    pop();
    cycle(1, 0, 2'b00, 0);
    idle();

    // Randomised traffic in phases biased toward full, empty and balanced occupancy.
    for (int ph = 0; ph < 4; ph++) begin
      int p_we;
      p_we = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      for (int i = 0; i < 100; i++) begin
        bit r, w, d;
        r = ($urandom_range(0, 99) == 0);
        w = ($urandom_range(0, 99) < p_we);
        d = ($urandom_range(0, 99) < (100 - p_we));
        cycle(r, w, 2'($urandom_range(0, 3)), d);
      end
    end

    idle(); idle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
